// File: rtl/alu_pkg.sv
// Shared opcode, state and helper definitions for the ALU request scheduler.
package alu_pkg;

  localparam logic [2:0] OP_PARITY    = 3'b000;
  localparam logic [2:0] OP_ROTR      = 3'b001;
  localparam logic [2:0] OP_ROTL      = 3'b010;
  localparam logic [2:0] OP_POPCOUNT  = 3'b011;
  localparam logic [2:0] OP_LEGAL_MAX = 3'b011;

  // state    | meaning
  // S_IDLE   | no op in flight, arbiter may grant
  // S_ISSUE  | ALU inputs valid for the first cycle, counter loaded
  // S_WAIT   | waiting out the remaining ALU latency
  // S_RESP   | result held for the granted requester until it takes it
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  function automatic logic op_is_legal(input logic [2:0] op);
    return (op <= OP_LEGAL_MAX);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone requester wins, a tie goes to the
// requester that was not granted last time.
module rr_arbiter2 (
  input  logic [1:0] req_valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o
);

  // Combinational grant selection.
  always_comb begin
    grant_o     = 2'b00;
    grant_idx_o = 1'b0;
    case (req_valid_i)
      2'b01: begin
        grant_o     = 2'b01;
        grant_idx_o = 1'b0;
      end
      2'b10: begin
        grant_o     = 2'b10;
        grant_idx_o = 1'b1;
      end
      2'b11: begin
        grant_idx_o = ~last_grant_i;
        grant_o     = last_grant_i ? 2'b01 : 2'b10;
      end
      default: begin
        grant_o     = 2'b00;
        grant_idx_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/alu_req_scheduler.sv
// Shares one ALU between two requesters: round-robin grant, one op in
// flight, fixed ALU latency wait, valid/ready response back to the winner.
module alu_req_scheduler
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 256,
  parameter int ALU_LATENCY = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [1:0]                req_valid,
  output logic [1:0]                req_ready,
  input  logic [5:0]                req_opcode,
  input  logic [2*DATA_WIDTH-1:0]   req_a,
  input  logic [2*DATA_WIDTH-1:0]   req_b,
  output logic [1:0]                rsp_valid,
  input  logic [1:0]                rsp_ready,
  output logic                      rsp_err,
  output logic [DATA_WIDTH-1:0]     rsp_data,
  output logic [2:0]                alu_opcode,
  output logic [DATA_WIDTH-1:0]     alu_a,
  output logic [DATA_WIDTH-1:0]     alu_b,
  input  logic [DATA_WIDTH-1:0]     alu_result,
  output logic                      busy
);

  // The ALU registers are loaded at accept so the ALU sees stable inputs
  // from the ISSUE cycle on; ISSUE is therefore the first latency cycle and
  // WAIT covers the remaining ALU_LATENCY-1 cycles (counter counts to 0).
  localparam logic [3:0] WAIT_INIT = (ALU_LATENCY > 1) ? 4'(ALU_LATENCY - 2) : 4'd0;

  state_e                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_grant_q, last_grant_d;
  logic                    illegal_q, illegal_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [2:0]              alu_opcode_q, alu_opcode_d;
  logic [DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [1:0]              rsp_valid_q, rsp_valid_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

  logic [1:0]              arb_grant;
  logic                    arb_idx;
  logic [2:0]              sel_op;
  logic [DATA_WIDTH-1:0]   sel_a;
  logic [DATA_WIDTH-1:0]   sel_b;
  logic [1:0]              grant_onehot;

  rr_arbiter2 u_arb (
    .req_valid_i  (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx)
  );

  assign sel_op       = arb_idx ? req_opcode[5:3] : req_opcode[2:0];
  assign sel_a        = arb_idx ? req_a[2*DATA_WIDTH-1:DATA_WIDTH] : req_a[DATA_WIDTH-1:0];
  assign sel_b        = arb_idx ? req_b[2*DATA_WIDTH-1:DATA_WIDTH] : req_b[DATA_WIDTH-1:0];
  assign grant_onehot = grant_q ? 2'b10 : 2'b01;

  // Next-state logic for the sequencing FSM and its datapath registers.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    illegal_d    = illegal_q;
    cnt_d        = cnt_q;
    alu_opcode_d = alu_opcode_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          grant_d   = arb_idx;
          illegal_d = ~op_is_legal(sel_op);
          rsp_err_d = 1'b0;
          // Illegal ops must leave the ALU inputs untouched.
          if (op_is_legal(sel_op)) begin
            alu_opcode_d = sel_op;
            alu_a_d      = sel_a;
            alu_b_d      = sel_b;
          end
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (illegal_q) begin
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          rsp_valid_d = grant_onehot;
          state_d     = S_RESP;
        end else if (ALU_LATENCY == 1) begin
          rsp_data_d  = alu_result;
          rsp_valid_d = grant_onehot;
          state_d     = S_RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = alu_result;
          rsp_valid_d = grant_onehot;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d  = 2'b00;
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      illegal_q    <= 1'b0;
      cnt_q        <= 4'd0;
      alu_opcode_q <= 3'b000;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      rsp_valid_q  <= 2'b00;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      illegal_q    <= illegal_d;
      cnt_q        <= cnt_d;
      alu_opcode_q <= alu_opcode_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE) ? arb_grant : 2'b00;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign alu_opcode = alu_opcode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;

endmodule
